// File: rtl/instr_fetch_if.sv
// Program-load and instruction-bus signals between the CU-side driver and instr_fetch.
// The slave modport is the fetch stage; the master modport is whoever loads and starts it.
interface instr_fetch_if #(
    parameter int INSTR_WIDTH = 20,
    parameter int PC_BITS     = 5
);
    logic                   prog_we;
    logic [PC_BITS-1:0]     prog_addr;
    logic [INSTR_WIDTH-1:0] prog_data;
    logic                   start;
    logic                   stall;
    logic [INSTR_WIDTH-1:0] instruction;
    logic [PC_BITS-1:0]     pc;
    logic                   instr_valid;
    logic                   busy;
    logic                   halted;

    modport slave (
        input  prog_we, prog_addr, prog_data, start, stall,
        output instruction, pc, instr_valid, busy, halted
    );

    modport master (
        output prog_we, prog_addr, prog_data, start, stall,
        input  instruction, pc, instr_valid, busy, halted
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction-supply stage: loadable program store, program counter and per-class
// hold timer that keeps each word on the CU bus for exactly its sequencer length.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | bus driven to zero, store writable, waiting for start
// S_FETCH | one cycle for the registered store read; bus keeps old word
// S_ISSUE | word held on bus while the hold down-counter runs out
// S_HALT  | class-00 word fetched; bus zero, store writable, restartable
module instr_fetch #(
    parameter int INSTR_WIDTH = 20,
    parameter int PC_BITS     = 5,
    parameter int HOLD_STD    = 3,
    parameter int HOLD_MEM    = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    instr_fetch_if.slave  bus
);

    localparam int CNT_W = $clog2(HOLD_MEM + 2);
    localparam logic [CNT_W-1:0] HOLD_STD_C = CNT_W'(HOLD_STD);
    localparam logic [CNT_W-1:0] HOLD_MEM_C = CNT_W'(HOLD_MEM);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_HALT
    } state_e;

    state_e                 state_q, state_d;
    logic [PC_BITS-1:0]     pc_q, pc_d;
    logic [INSTR_WIDTH-1:0] instr_q, instr_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   first_q, first_d;
    logic                   pend_q, pend_d;

    logic [INSTR_WIDTH-1:0] mem_q [2**PC_BITS];
    logic [INSTR_WIDTH-1:0] rd_data_q;
    logic [1:0]             rd_class;
    logic                   wr_en;

    assign wr_en    = bus.prog_we && ((state_q == S_IDLE) || (state_q == S_HALT));
    assign rd_class = rd_data_q[INSTR_WIDTH-1 -: 2];

    // Store is not reset; the read tracks pc_d so the word is ready during FETCH.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[bus.prog_addr] <= bus.prog_data;
        end
        rd_data_q <= mem_q[pc_d];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            instr_q <= '0;
            cnt_q   <= '0;
            first_q <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            cnt_q   <= cnt_d;
            first_q <= first_d;
            pend_q  <= pend_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        cnt_d   = cnt_q;
        first_d = first_q;
        pend_d  = pend_q;

        unique case (state_q)
            S_IDLE, S_HALT: begin
                instr_d = '0;
                pend_d  = 1'b0;
                // A write and a start in the same cycle: the write wins.
                if (bus.start && !bus.prog_we) begin
                    state_d = S_FETCH;
                    pc_d    = '0;
                    first_d = 1'b1;
                end
            end

            S_FETCH: begin
                first_d = 1'b0;
                if (rd_class == 2'b00) begin
                    state_d = S_HALT;
                    instr_d = '0;
                end else begin
                    state_d = S_ISSUE;
                    instr_d = rd_data_q;
                    pend_d  = 1'b1;
                    // The extra cycle on the first word covers CU RESET->DECODE.
                    cnt_d   = ((rd_class == 2'b01) ? HOLD_STD_C : HOLD_MEM_C)
                              + CNT_W'(first_q);
                end
            end

            S_ISSUE: begin
                if (!bus.stall) begin
                    pend_d = 1'b0;
                    cnt_d  = cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = S_FETCH;
                        pc_d    = pc_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Valid marks the first non-stalled issue cycle of each word.
    assign bus.instruction = instr_q;
    assign bus.pc          = pc_q;
    assign bus.instr_valid = pend_q && !bus.stall && (state_q == S_ISSUE);
    assign bus.busy        = (state_q == S_FETCH) || (state_q == S_ISSUE);
    assign bus.halted      = (state_q == S_HALT);

endmodule
